// File: rtl/msrv32_pkg.sv
// Shared definitions for the MSRV32 fetch path: FSM encoding, opcode groups
// and small address helpers.
package msrv32_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT      = 2'd1,
        WAIT_TRAP = 2'd2
    } pc_state_e;

    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;

    localparam logic [31:0] PC_STEP = 32'd4;

    // JALR semantics: bit 0 of the computed target is always dropped.
    function automatic logic [31:0] clean_target(input logic [31:0] addr);
        return {addr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/msrv32_next_pc_mux.sv
// Combinational next-fetch-address select: trap beats an aligned taken
// branch, which beats sequential fetch. A taken branch whose cleaned target
// is not word aligned never redirects; it only raises the misaligned flag.
module msrv32_next_pc_mux
    import msrv32_pkg::*;
(
    input  logic        branch_taken_i,
    input  logic [31:0] iaddr_i,
    input  logic        trap_taken_i,
    input  logic [31:0] trap_address_i,
    input  logic [31:0] i_addr_i,
    output logic [31:0] next_addr_o,
    output logic        redirect_o,
    output logic        misaligned_o
);

    logic [31:0] tgt_s;
    logic [31:0] seq_s;

    // Priority select of the next fetch address and misaligned detection.
    always_comb begin
        tgt_s        = clean_target(iaddr_i);
        seq_s        = i_addr_i + PC_STEP;
        next_addr_o  = seq_s;
        redirect_o   = 1'b0;
        misaligned_o = branch_taken_i & tgt_s[1] & ~trap_taken_i;
        if (trap_taken_i) begin
            next_addr_o = trap_address_i;
            redirect_o  = 1'b1;
        end else if (branch_taken_i && !tgt_s[1]) begin
            next_addr_o = tgt_s;
            redirect_o  = 1'b1;
        end else begin
            next_addr_o = seq_s;
            redirect_o  = 1'b0;
        end
    end

endmodule

// File: rtl/msrv32_pc_gen.sv
// Program-counter generator: registered fetch address, execute-stage PC,
// one-bubble flush after every redirect, and stall handling that keeps a
// trap request raised during an instruction-memory wait.
module msrv32_pc_gen
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iaddr_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_address_in,
    input  logic        imem_ready_in,
    output logic [31:0] i_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
);

    pc_state_e   state_q, state_d;
    logic [31:0] i_addr_q, i_addr_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic [31:0] next_addr_s;
    logic        redirect_s;

    msrv32_next_pc_mux u_next_pc_mux (
        .branch_taken_i (branch_taken_in),
        .iaddr_i        (iaddr_in),
        .trap_taken_i   (trap_taken_in),
        .trap_address_i (trap_address_in),
        .i_addr_i       (i_addr_q),
        .next_addr_o    (next_addr_s),
        .redirect_o     (redirect_s),
        .misaligned_o   (misaligned_instr_out)
    );

    // Next-state logic: advance on ready, otherwise hold and park any trap.
    always_comb begin
        state_d      = state_q;
        i_addr_d     = i_addr_q;
        pc_d         = pc_q;
        flush_d      = flush_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        case (state_q)
            RUN, WAIT: begin
                if (imem_ready_in) begin
                    pc_d     = i_addr_q;
                    i_addr_d = next_addr_s;
                    flush_d  = redirect_s;
                    state_d  = RUN;
                end else if (trap_taken_in) begin
                    pend_addr_d  = trap_address_in;
                    pend_valid_d = 1'b1;
                    state_d      = WAIT_TRAP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT_TRAP: begin
                // Parked trap owns the next redirect; live requests are ignored.
                if (imem_ready_in) begin
                    pc_d         = i_addr_q;
                    i_addr_d     = pend_addr_q;
                    flush_d      = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = RUN;
                end else begin
                    state_d = WAIT_TRAP;
                end
            end
            default: begin
                // Illegal encoding: resume sequential operation and kill execute.
                state_d      = RUN;
                flush_d      = 1'b1;
                pend_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset to the boot vector.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q      <= RUN;
            i_addr_q     <= BOOT_ADDRESS;
            pc_q         <= BOOT_ADDRESS - PC_STEP;
            flush_q      <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            i_addr_q     <= i_addr_d;
            pc_q         <= pc_d;
            flush_q      <= flush_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign i_addr_out    = i_addr_q;
    assign pc_out        = pc_q;
    assign flush_out     = flush_q;
    assign pc_plus_4_out = pc_q + PC_STEP;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Scoreboard bench for msrv32_pc_gen: the driver applies directed and random
// stimulus, predicts the post-edge outputs from a rule-level model and queues
// them; a negedge monitor pops and compares.
module tb_msrv32_pc_gen;

    localparam logic [31:0] BOOT = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        br;
    logic [31:0] ia;
    logic        tr;
    logic [31:0] ta;
    logic        rdy;
    logic [31:0] i_addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        flush;
    logic        mis;

    typedef struct {
        logic [31:0] ia;
        logic [31:0] pc;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view of fetch, execute PC and a parked trap.
    logic [31:0] m_fetch;
    logic [31:0] m_pc;
    logic        m_flush;
    logic        m_pending;
    logic [31:0] m_trap_addr;
    bit          saw_300;

    msrv32_pc_gen #(.BOOT_ADDRESS(BOOT)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .branch_taken_in      (br),
        .iaddr_in             (ia),
        .trap_taken_in        (tr),
        .trap_address_in      (ta),
        .imem_ready_in        (rdy),
        .i_addr_out           (i_addr),
        .pc_out               (pc),
        .pc_plus_4_out        (pc4),
        .flush_out            (flush),
        .misaligned_instr_out (mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare the outputs seen after each edge with the queued prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("i_addr", i_addr, e.ia);
            chk("pc", pc, e.pc);
            chk("pc_plus_4", pc4, e.pc + 32'd4);
            chk("flush", {31'd0, flush}, {31'd0, e.fl});
            chk("misaligned", {31'd0, mis}, {31'd0, e.mis});
        end
    end

    // One clock: apply inputs, predict, queue, then step past the next negedge.
    task automatic cycle(input bit r, input bit b, input logic [31:0] a,
                         input bit t, input logic [31:0] tv, input bit rd);
        exp_t e;
        logic [31:0] tgt;
        rst = r; br = b; ia = a; tr = t; ta = tv; rdy = rd;
        tgt   = a & 32'hFFFF_FFFE;
        e.mis = b && tgt[1] && !t;
        if (r) begin
            m_fetch   = BOOT;
            m_pc      = BOOT - 32'd4;
            m_flush   = 1'b1;
            m_pending = 1'b0;
        end else if (m_pending) begin
            if (rd) begin
                m_pc      = m_fetch;
                m_fetch   = m_trap_addr;
                m_flush   = 1'b1;
                m_pending = 1'b0;
            end
        end else if (!rd) begin
            if (t) begin
                m_pending   = 1'b1;
                m_trap_addr = tv;
            end
        end else begin
            m_pc = m_fetch;
            if (t) begin
                m_fetch = tv;
                m_flush = 1'b1;
            end else if (b && !tgt[1]) begin
                m_fetch = tgt;
                m_flush = 1'b1;
            end else begin
                m_fetch = m_fetch + 32'd4;
                m_flush = 1'b0;
            end
        end
        e.ia = m_fetch;
        e.pc = m_pc;
        e.fl = m_flush;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; br = 1'b0; ia = 32'd0; tr = 1'b0; ta = 32'd0; rdy = 1'b1;
        m_fetch = BOOT; m_pc = BOOT - 32'd4; m_flush = 1'b1;
        m_pending = 1'b0; m_trap_addr = 32'd0; saw_300 = 1'b0;

        // Reset, then sequential fetch from the boot vector.
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 100 && m_fetch != 32'h204; k++)
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

        // Taken branch to 0x80, then one sequential step.
        cycle(1'b0, 1'b1, 32'h80, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

        // JALR target cleaning and misaligned target.
        cycle(1'b0, 1'b1, 32'h81, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'h82, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

        // Branch and trap together: trap wins, misaligned suppressed.
        cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h1C0, 1'b1);
        cycle(1'b0, 1'b1, 32'h42, 1'b1, 32'h1C0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

        // Trap pulsed during a 3-cycle stall, released afterwards.
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h300, 1'b0);
        cycle(1'b0, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h500, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

        // Same stall, but reset arrives mid-stall and discards the parked trap.
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h300, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
            if (i_addr == 32'h300) saw_300 = 1'b1;
        end
        chk("no_lost_reset_trap", {31'd0, saw_300}, 32'd0);

        // Plain stall without trap, then a branch evaluated on release.
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h1000, 1'b0, 32'd0, 1'b1);

        // Wrap of the sequential add.
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ra;
            logic [31:0] rt;
            ra = $urandom();
            rt = $urandom();
            cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 25, ra,
                  $urandom_range(0, 99) < 10, rt,
                  $urandom_range(0, 99) < 70);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
